// File: rtl/cpu_pkg.sv
// Shared CPU-wide widths and the writeback queue entry type.
package cpu_pkg;

    localparam int REG_ADDR_W = 6;
    localparam int REG_DATA_W = 32;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_lookup.sv
// Youngest-match bypass search over the writeback queue, scanning from head.
module wb_lookup
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  wb_entry_t             entries [DEPTH],
    input  logic [$clog2(DEPTH)-1:0] head,
    input  logic [REG_ADDR_W-1:0] addr,
    output logic                  hit,
    output logic [REG_DATA_W-1:0] data
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] idx;

    // Walk oldest to youngest so the last match seen is the one closest to tail.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = head;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if (entries[idx].valid && (entries[idx].addr == addr) && (addr != ZERO_REG)) begin
                hit  = 1'b1;
                data = entries[idx].data;
            end
        end
    end

endmodule

// File: rtl/reg_write_buffer.sv
// In-order writeback queue in front of RegisterFile's single write port,
// with two bypass lookup ports over the queued entries.
module reg_write_buffer
    import cpu_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     inValid,
    output logic                     inReady,
    input  logic [ADDR_W-1:0]        inAddr,
    input  logic [DATA_W-1:0]        inData,
    input  logic                     hold,
    output logic                     writeEn,
    output logic [ADDR_W-1:0]        writeAddr,
    output logic [DATA_W-1:0]        writeData,
    input  logic [ADDR_W-1:0]        lookupAddr1,
    input  logic [ADDR_W-1:0]        lookupAddr2,
    output logic                     lookupHit1,
    output logic [DATA_W-1:0]        lookupData1,
    output logic                     lookupHit2,
    output logic [DATA_W-1:0]        lookupData2,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_entry_t        entries [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic             push;
    logic             pop;
    logic             notEmpty;

    assign notEmpty = (count != '0);

    // Gated by rst so queued entries are discarded rather than committed.
    assign writeEn   = notEmpty && !hold && !rst;
    assign writeAddr = notEmpty ? entries[head].addr : '0;
    assign writeData = notEmpty ? entries[head].data : '0;

    assign inReady = (count < CNT_W'(DEPTH)) || writeEn;
    assign pop     = writeEn;
    assign push    = inValid && inReady && (inAddr != ZERO_REG);

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entries[i].valid <= 1'b0;
            end
        end else begin
            // Pop before push: when full, push and pop share an index and the new entry must win.
            if (pop) begin
                entries[head].valid <= 1'b0;
                head <= head + PTR_W'(1);
            end
            if (push) begin
                entries[tail] <= '{valid: 1'b1, addr: inAddr, data: inData};
                tail <= tail + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    wb_lookup #(.DEPTH(DEPTH)) lookup1 (
        .entries (entries),
        .head    (head),
        .addr    (lookupAddr1),
        .hit     (lookupHit1),
        .data    (lookupData1)
    );

    wb_lookup #(.DEPTH(DEPTH)) lookup2 (
        .entries (entries),
        .head    (head),
        .addr    (lookupAddr2),
        .hit     (lookupHit2),
        .data    (lookupData2)
    );

endmodule

// File: tb/tb_reg_write_buffer.sv
// Self-checking bench: directed vector table, then random traffic against a queue model.
module tb_reg_write_buffer;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 6;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              inValid;
    logic              inReady;
    logic [ADDR_W-1:0] inAddr;
    logic [DATA_W-1:0] inData;
    logic              hold;
    logic              writeEn;
    logic [ADDR_W-1:0] writeAddr;
    logic [DATA_W-1:0] writeData;
    logic [ADDR_W-1:0] lookupAddr1;
    logic [ADDR_W-1:0] lookupAddr2;
    logic              lookupHit1;
    logic [DATA_W-1:0] lookupData1;
    logic              lookupHit2;
    logic [DATA_W-1:0] lookupData2;
    logic [$clog2(DEPTH):0] count;

    reg_write_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .inValid(inValid), .inReady(inReady),
        .inAddr(inAddr), .inData(inData), .hold(hold),
        .writeEn(writeEn), .writeAddr(writeAddr), .writeData(writeData),
        .lookupAddr1(lookupAddr1), .lookupAddr2(lookupAddr2),
        .lookupHit1(lookupHit1), .lookupData1(lookupData1),
        .lookupHit2(lookupHit2), .lookupData2(lookupData2),
        .count(count)
    );

    always #5 clk = ~clk;

    // RegisterFile stand-in fed by the DUT write port.
    logic [DATA_W-1:0] rf [64];
    initial for (int i = 0; i < 64; i++) rf[i] = '0;
    always @(posedge clk) if (writeEn) rf[writeAddr] <= writeData;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } qent_t;

    typedef struct {
        logic              v;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        logic              h;
        logic              r;
        logic [ADDR_W-1:0] la1;
        logic [ADDR_W-1:0] la2;
        logic              eReady;
        int                eCount;
        logic              eWe;
        logic              eHit1;
        logic [DATA_W-1:0] eData1;
        logic              eHit2;
    } vec_t;

    qent_t             q[$];
    logic [DATA_W-1:0] expRf [64];
    int                compared   = 0;
    int                mismatched = 0;
    vec_t              tv [23];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelLookup(input logic [ADDR_W-1:0] a, output logic hit, output logic [DATA_W-1:0] d);
        hit = 1'b0;
        d   = '0;
        if (a != 0) begin
            for (int i = q.size() - 1; i >= 0; i--) begin
                if (q[i].addr == a) begin
                    hit = 1'b1;
                    d   = q[i].data;
                    break;
                end
            end
        end
    endtask

    // One cycle: drive at negedge, check before posedge, update model after posedge.
    task automatic step(input vec_t t, input bit useTable, output bit accepted);
        logic              eWe, eReady, h1, h2;
        logic [DATA_W-1:0] d1, d2;
        inValid = t.v; inAddr = t.a; inData = t.d; hold = t.h; rst = t.r;
        lookupAddr1 = t.la1; lookupAddr2 = t.la2;
        #1;
        eWe    = !t.r && (q.size() != 0) && !t.h;
        eReady = (q.size() < DEPTH) || eWe;
        modelLookup(t.la1, h1, d1);
        modelLookup(t.la2, h2, d2);
        chk("count", 32'(count), 32'(q.size()));
        chk("writeEn", 32'(writeEn), 32'(eWe));
        chk("inReady", 32'(inReady), 32'(eReady));
        chk("writeAddr", 32'(writeAddr), q.size() != 0 ? 32'(q[0].addr) : 32'd0);
        chk("writeData", writeData, q.size() != 0 ? q[0].data : 32'd0);
        chk("lookupHit1", 32'(lookupHit1), 32'(h1));
        chk("lookupData1", lookupData1, d1);
        chk("lookupHit2", 32'(lookupHit2), 32'(h2));
        chk("lookupData2", lookupData2, d2);
        if (useTable) begin
            chk("tbl_count", 32'(count), 32'(t.eCount));
            chk("tbl_writeEn", 32'(writeEn), 32'(t.eWe));
            chk("tbl_inReady", 32'(inReady), 32'(t.eReady));
            chk("tbl_hit1", 32'(lookupHit1), 32'(t.eHit1));
            chk("tbl_data1", lookupData1, t.eData1);
            chk("tbl_hit2", 32'(lookupHit2), 32'(t.eHit2));
        end
        accepted = t.v && eReady;
        @(posedge clk);
        if (t.r) begin
            q.delete();
        end else begin
            if (eWe) begin
                expRf[q[0].addr] = q[0].data;
                void'(q.pop_front());
            end
            if (accepted && t.a != 0) q.push_back('{addr: t.a, data: t.d});
        end
        @(negedge clk);
    endtask

    task automatic rfCheck(input int a, input logic [DATA_W-1:0] exp);
        chk($sformatf("rf[%0d]", a), rf[a], exp);
    endtask

    initial begin
        bit   acc;
        vec_t rv;
        for (int i = 0; i < 64; i++) expRf[i] = '0;
        //          v  a   d             h  r  la1 la2  rdy cnt we hit1 data1         hit2
        tv[0]  = '{0, 0,  32'h0,        0, 0, 5,  10,  1,  0,  0, 0, 32'h0,        0};
        tv[1]  = '{1, 5,  32'hAAAABBBB, 0, 0, 5,  0,   1,  0,  0, 0, 32'h0,        0};
        tv[2]  = '{1, 10, 32'h12345678, 0, 0, 5,  10,  1,  1,  1, 1, 32'hAAAABBBB, 0};
        tv[3]  = '{1, 15, 32'hDEADBEEF, 0, 0, 10, 5,   1,  1,  1, 1, 32'h12345678, 0};
        tv[4]  = '{0, 0,  32'h0,        0, 0, 15, 10,  1,  1,  1, 1, 32'hDEADBEEF, 0};
        tv[5]  = '{0, 0,  32'h0,        0, 0, 15, 0,   1,  0,  0, 0, 32'h0,        0};
        tv[6]  = '{1, 5,  32'h1,        1, 0, 5,  0,   1,  0,  0, 0, 32'h0,        0};
        tv[7]  = '{1, 6,  32'h2,        1, 0, 5,  6,   1,  1,  0, 1, 32'h1,        0};
        tv[8]  = '{1, 5,  32'h3,        1, 0, 5,  6,   1,  2,  0, 1, 32'h1,        1};
        tv[9]  = '{1, 7,  32'h4,        1, 0, 5,  7,   1,  3,  0, 1, 32'h3,        0};
        tv[10] = '{1, 9,  32'h0000CAFE, 1, 0, 5,  8,   0,  4,  0, 1, 32'h3,        0};
        tv[11] = '{1, 9,  32'h0000CAFE, 0, 0, 5,  8,   1,  4,  1, 1, 32'h3,        0};
        tv[12] = '{0, 0,  32'h0,        0, 0, 9,  5,   1,  4,  1, 1, 32'h0000CAFE, 1};
        tv[13] = '{0, 0,  32'h0,        0, 0, 6,  7,   1,  3,  1, 0, 32'h0,        1};
        tv[14] = '{0, 0,  32'h0,        0, 0, 7,  9,   1,  2,  1, 1, 32'h4,        1};
        tv[15] = '{0, 0,  32'h0,        0, 0, 9,  7,   1,  1,  1, 1, 32'h0000CAFE, 0};
        tv[16] = '{1, 0,  32'hFFFFFFFF, 0, 0, 0,  9,   1,  0,  0, 0, 32'h0,        0};
        tv[17] = '{0, 0,  32'h0,        0, 0, 0,  0,   1,  0,  0, 0, 32'h0,        0};
        tv[18] = '{1, 20, 32'h11,       1, 0, 20, 0,   1,  0,  0, 0, 32'h0,        0};
        tv[19] = '{1, 21, 32'h22,       1, 0, 20, 21,  1,  1,  0, 1, 32'h11,       0};
        tv[20] = '{1, 22, 32'h33,       1, 0, 20, 21,  1,  2,  0, 1, 32'h11,       1};
        tv[21] = '{0, 0,  32'h0,        0, 1, 22, 0,   1,  3,  0, 1, 32'h33,       0};
        tv[22] = '{0, 0,  32'h0,        0, 0, 20, 22,  1,  0,  0, 0, 32'h0,        0};

        inValid = 0; inAddr = '0; inData = '0; hold = 0; rst = 1;
        lookupAddr1 = '0; lookupAddr2 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        for (int i = 0; i < 23; i++) begin
            step(tv[i], 1'b1, acc);
            if (i == 17) begin
                rfCheck(5, 32'h3); rfCheck(6, 32'h2); rfCheck(7, 32'h4);
                rfCheck(9, 32'h0000CAFE); rfCheck(10, 32'h12345678);
                rfCheck(15, 32'hDEADBEEF); rfCheck(0, 32'h0);
            end
        end
        rfCheck(20, 32'h0); rfCheck(21, 32'h0); rfCheck(22, 32'h0);
        rfCheck(5, 32'h3);

        // Random traffic over a small address set to force collisions and wraps.
        rv = tv[0];
        rv.v = 1'b0;
        for (int n = 0; n < 600; n++) begin
            if (!rv.v || acc) begin
                rv.v = ($urandom_range(0, 3) != 0);
                rv.a = ADDR_W'($urandom_range(0, 7));
                rv.d = $urandom;
            end
            rv.h   = ($urandom_range(0, 3) == 0);
            rv.r   = ($urandom_range(0, 99) == 0);
            rv.la1 = ADDR_W'($urandom_range(0, 7));
            rv.la2 = ADDR_W'($urandom_range(0, 7));
            step(rv, 1'b0, acc);
            if (rv.r) acc = 1'b1;
        end
        rv = tv[0];
        for (int n = 0; n < DEPTH + 2; n++) step(rv, 1'b0, acc);
        for (int i = 0; i < 64; i++) rfCheck(i, expRf[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/reg_write_buffer.md
Name: reg_write_buffer

Overview:
- Write-side companion to RegisterFile.
- Accepts register writeback requests from the pipeline over a valid/ready handshake and queues them in a small in-order FIFO.
- Drains the FIFO one entry per cycle into RegisterFile's single write port (writeEn/writeAddr/writeData).
- Provides two bypass lookup ports so decode can see values that are queued but not yet written.

Parameters:
- DEPTH, 4, number of queued write entries; power of two, minimum 2.
- ADDR_W, 6, register address width; matches RegisterFile address ports.
- DATA_W, 32, register data width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- inValid  input  1  writeback request present.
- inReady  output  1  buffer can accept this cycle.
- inAddr  input  ADDR_W  destination register.
- inData  input  DATA_W  value to write.
- hold  input  1  RegisterFile write port unavailable; blocks the drain this cycle.
- writeEn  output  1  to RegisterFile.writeEn.
- writeAddr  output  ADDR_W  to RegisterFile.writeAddr.
- writeData  output  DATA_W  to RegisterFile.writeData.
- lookupAddr1  input  ADDR_W  bypass query 1.
- lookupAddr2  input  ADDR_W  bypass query 2.
- lookupHit1  output  1  a queued entry matches lookupAddr1.
- lookupData1  output  DATA_W  youngest matching value for query 1.
- lookupHit2  output  1  a queued entry matches lookupAddr2.
- lookupData2  output  DATA_W  youngest matching value for query 2.
- count  output  $clog2(DEPTH)+1  occupied entries.

Behaviour:
- Reset (rst=1 at a rising edge):
  - head, tail and count all go to 0; every entry valid bit is cleared.
  - Outputs after reset: writeEn=0, writeAddr=0, writeData=0, lookupHit1=0, lookupHit2=0, lookupData1=0, lookupData2=0, inReady=1.
  - Reset takes priority over push and pop in the same cycle; queued entries are discarded, not written.
- Drain:
  - writeEn = (count!=0) & !hold. writeAddr and writeData come combinationally from the head entry; they are 0 when empty.
  - A pop occurs on every edge where writeEn=1, so RegisterFile commits the head on that same edge.
- Accept:
  - inReady = (count<DEPTH) | writeEn, so a full buffer that is draining accepts in the same cycle.
  - A push occurs when inValid & inReady.
  - Requests with inAddr==0 are accepted (handshake completes) but not enqueued, because register 0 is hardwired to zero.
- Simultaneous push and pop: count is unchanged; head and tail both advance.
- Pointers wrap modulo DEPTH.
- Ordering: strictly FIFO. Two writes to the same address commit in arrival order, so the final RegisterFile value is the newer one.
- Latency:
  - An accepted request to an empty, unheld buffer is enqueued at edge N and written to RegisterFile at edge N+1.
  - It is visible via RegisterFile reads after edge N+1, and via lookup from edge N onward.
- Lookup (combinational over queued entries only; the entry being pushed this cycle is not visible):
  - Hit = any valid entry with a matching address.
  - Data = youngest matching entry, closest to tail.
  - lookupAddr==0 never hits, and data is 0 on a miss.
  - An entry popping this cycle is still reported, since RegisterFile has not yet updated.
- hold asserted with the buffer full: inReady=0, and the contents and outputs stay stable.
- inValid with inReady=0 leaves state unchanged; the producer must keep inAddr/inData stable until accepted.

Decomposition:
- Shared package cpu_pkg:
  - REG_ADDR_W=6, REG_DATA_W=32, ZERO_REG='0.
  - typedef wb_entry_t {logic valid; logic [REG_ADDR_W-1:0] addr; logic [REG_DATA_W-1:0] data;}.
- One natural sub-module, wb_lookup: a combinational youngest-match priority search over the entry array, given head. It is instantiated twice, once per query port.

Test Plan:
- Reset then idle, inValid=0 -> writeEn=0, count=0, inReady=1, both lookupHit=0.
- Push addr5=AAAABBBB, addr10=12345678, addr15=DEADBEEF on consecutive cycles, hold=0 -> RegisterFile is written in the same order one cycle after each push; reading 5/10/15 then returns those values, and reading 0 returns 0.
- hold=1 and push 4 entries (5=1, 6=2, 5=3, 7=4) -> count=4, inReady=0. lookupAddr1=5 gives hit, 00000003. lookupAddr2=8 gives no hit, 0. Release hold -> four writes in order; register 5 ends at 00000003.
- Full and hold=0 with inValid=1 (addr9=0000CAFE) -> inReady=1, count stays 4 and advances; the 9 write arrives after the 4 older ones.
- Push inAddr=0, inData=FFFFFFFF -> handshake completes, count is unchanged, no writeEn, register 0 reads 0.
- With 3 entries queued, assert rst for one cycle -> count=0, writeEn=0, no pending writes reach RegisterFile; previously written registers are unaffected.
